imem_uart_loader: RTL and testbench

Loads a program image into the CPU's instruction memory over a serial line while the CPU is held, so new code runs without regenerating the ROM image. It receives 8N1 UART bytes, checks a framed packet, assembles little-endian 32-bit words and drives a word-wide write port into the instruction memory. It also drives a hold signal that freezes the PC counter while a load is in progress.

---
 rtl/imem_uart_loader_pkg.sv | 27 ++
 rtl/uart_rx_byte.sv | 119 +++++++++++
 rtl/imem_uart_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_uart_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: packet header,
// FSM encodings and the bit-period helper.
package imem_uart_loader_pkg;

  localparam logic [7:0] LDR_HDR = 8'hA5;

  typedef enum logic [2:0] {
    L_IDLE,
    L_COUNT,
    L_DATA,
    L_CSUM,
    L_DONE,
    L_ERR
  } ldr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// mid-bit sampling, one-cycle rx_valid / rx_ferr pulses.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_reg;
  logic             line_prev_reg;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       byte_reg, byte_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;
  logic             line;

  assign line     = sync_reg[1];
  assign rx_byte  = byte_reg;
  assign rx_valid = valid_reg;
  assign rx_ferr  = ferr_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg      <= 2'b11;
      line_prev_reg <= 1'b1;
      state_reg     <= RX_IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      byte_reg      <= '0;
      valid_reg     <= 1'b0;
      ferr_reg      <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], uart_rx};
      line_prev_reg <= line;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      byte_reg      <= byte_next;
      valid_reg     <= valid_next;
      ferr_reg      <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_next  = byte_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        if (line_prev_reg && !line) begin
          state_next = RX_START;
          cnt_next   = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = line ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next   = '0;
          shift_next = {line, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          if (line) begin
            valid_next = 1'b1;
            byte_next  = shift_reg;
          end else begin
            ferr_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = RX_IDLE;
    endcase
    if (!enable) begin
      state_next = RX_IDLE;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads framed program images received over UART into instruction memory,
// holding the CPU while a packet is in flight.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int ADDR_WIDTH   = 6,
  parameter int MAX_WORDS    = 64,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_en,
  input  logic                  uart_rx,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam int CPB            = clks_per_bit(CLK_FREQ, BAUD);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CPB;
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk     (clk),
    .rstn    (rstn),
    .enable  (load_en),
    .uart_rx (uart_rx),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  ldr_state_t            state_reg, state_next;
  logic [7:0]            count_reg, count_next;
  logic [7:0]            widx_reg, widx_next;
  logic [1:0]            lane_reg, lane_next;
  logic [7:0]            csum_reg, csum_next;
  logic [31:0]           asm_reg, asm_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;
  logic                  busy;
  logic                  timeout;

  assign busy     = (state_reg == L_COUNT) || (state_reg == L_DATA) || (state_reg == L_CSUM);
  assign timeout  = busy && !rx_valid && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
  assign we       = we_reg;
  assign waddr    = waddr_reg;
  assign wdata    = wdata_reg;
  assign cpu_hold = busy;
  assign done     = done_reg;
  assign err      = err_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= L_IDLE;
      count_reg <= '0;
      widx_reg  <= '0;
      lane_reg  <= '0;
      csum_reg  <= '0;
      asm_reg   <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      widx_reg  <= widx_next;
      lane_reg  <= lane_next;
      csum_reg  <= csum_next;
      asm_reg   <= asm_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    widx_next  = widx_reg;
    lane_next  = lane_reg;
    csum_next  = csum_reg;
    asm_next   = asm_reg;
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    timer_next = (busy && !rx_valid) ? timer_reg + TMR_W'(1) : '0;

    case (state_reg)
      L_IDLE, L_DONE, L_ERR: begin
        if (rx_valid && rx_byte == LDR_HDR) begin
          state_next = L_COUNT;
          done_next  = 1'b0;
          err_next   = 1'b0;
        end
      end
      L_COUNT: begin
        if (rx_valid) begin
          if (rx_byte == 8'd0 || rx_byte > 8'(MAX_WORDS)) begin
            state_next = L_ERR;
            err_next   = 1'b1;
          end else begin
            count_next = rx_byte;
            widx_next  = '0;
            lane_next  = '0;
            csum_next  = '0;
            state_next = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (rx_valid) begin
          csum_next = csum_reg ^ rx_byte;
          lane_next = lane_reg + 2'd1;
          asm_next[{lane_reg, 3'b000} +: 8] = rx_byte;
          if (lane_reg == 2'd3) begin
            we_next    = 1'b1;
            waddr_next = ADDR_WIDTH'(widx_reg);
            wdata_next = {rx_byte, asm_reg[23:0]};
            widx_next  = widx_reg + 8'd1;
            if (widx_reg + 8'd1 == count_reg) state_next = L_CSUM;
          end
        end
      end
      L_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_reg) begin
            state_next = L_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = L_ERR;
            err_next   = 1'b1;
          end
        end
      end
      default: state_next = L_IDLE;
    endcase

    if (busy && (rx_ferr || timeout)) begin
      state_next = L_ERR;
      err_next   = 1'b1;
      done_next  = 1'b0;
      we_next    = 1'b0;
    end

    // Switching the loader off abandons the packet but keeps the last verdict.
    if (!load_en) begin
      state_next = L_IDLE;
      we_next    = 1'b0;
      done_next  = done_reg;
      err_next   = err_reg;
      timer_next = '0;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serial byte stimulus, write scoreboard,
// status and hold checks at 16 clocks per bit.
module tb_imem_uart_loader;

  localparam int CPB   = 16;
  localparam int BYTE_T = 10 * CPB;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_en = 1'b0;
  logic        uart_rx = 1'b1;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  chk_cnt  = 0;
  int  pass_cnt = 0;
  int  hold_cnt = 0;
  logic we_prev = 1'b0;

  imem_uart_loader #(
    .CLK_FREQ    (1600),
    .BAUD        (100),
    .ADDR_WIDTH  (6),
    .MAX_WORDS   (4),
    .TIMEOUT_BITS(40)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .load_en (load_en),
    .uart_rx (uart_rx),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn) begin
      if (cpu_hold) hold_cnt++;
      if (we) begin
        check("we_single_cycle", 32'(we_prev), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_we", 32'(waddr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("waddr", 32'(waddr), 32'(e.addr));
          check("wdata", wdata, e.data);
          $display("write addr=%0d data=%08h", waddr, wdata);
        end
      end
      we_prev = we;
    end else begin
      we_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop_bit;
    idle(CPB);
    uart_rx = 1'b1;
    $display("sent byte %02h stop=%0b", b, stop_bit);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
  endtask

  task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_status(input string tag, input logic h, input logic d, input logic e);
    check({tag, "_hold"}, 32'(cpu_hold), 32'(h));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    logic [7:0] pkt[$];

    // Reset state
    idle(3);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    load_en = 1'b1;
    idle(5);

    // 1: nominal two-word load
    send_byte(8'hA5, 1'b1);
    check("t1_hold_after_hdr", 32'(cpu_hold), 32'd1);
    expect_wr(6'd0, 32'h0000_0013);
    expect_wr(6'd1, 32'h0050_0293);
    pkt = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'hD2};
    send_seq(pkt);
    check_status("t1", 1'b0, 1'b1, 1'b0);
    check("t1_sb_left", 32'(sb.size()), 32'd0);
    idle(20);

    // 2: bad checksum, words still written
    expect_wr(6'd0, 32'h0000_0013);
    expect_wr(6'd1, 32'h0050_0293);
    pkt = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'hD3};
    send_seq(pkt);
    check_status("t2", 1'b0, 1'b0, 1'b1);
    check("t2_sb_left", 32'(sb.size()), 32'd0);
    idle(20);

    // 3: illegal counts, hold lasts exactly one byte time
    hold_cnt = 0;
    pkt = '{8'hA5, 8'h00};
    send_seq(pkt);
    idle(20);
    check_status("t3_zero", 1'b0, 1'b0, 1'b1);
    check("t3_zero_hold_len", 32'(hold_cnt), 32'(BYTE_T));
    hold_cnt = 0;
    pkt = '{8'hA5, 8'h05};
    send_seq(pkt);
    idle(20);
    check_status("t3_big", 1'b0, 1'b0, 1'b1);
    check("t3_big_hold_len", 32'(hold_cnt), 32'(BYTE_T));

    // 3b: max legal count is accepted (no error, holding for data)
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    check_status("t3_max", 1'b1, 1'b0, 1'b0);
    idle(700);
    check_status("t3_max_to", 1'b0, 1'b0, 1'b1);

    // 4: framing error, then inter-byte timeout
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b0);
    idle(20);
    check_status("t4_ferr", 1'b0, 1'b0, 1'b1);
    pkt = '{8'hA5, 8'h01, 8'h13};
    send_seq(pkt);
    idle(600);
    check_status("t4_before_to", 1'b1, 1'b0, 1'b0);
    idle(50);
    check_status("t4_after_to", 1'b0, 1'b0, 1'b1);
    idle(20);

    // 5: start glitch and noise byte ignored
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(40);
    expect_wr(6'd0, 32'h1300_0013);
    pkt = '{8'h55, 8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h13, 8'h00};
    send_seq(pkt);
    check_status("t5", 1'b0, 1'b1, 1'b0);
    check("t5_sb_left", 32'(sb.size()), 32'd0);
    idle(20);

    // 6a: loader switched off during word 1
    expect_wr(6'd0, 32'hDDCC_BBAA);
    pkt = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_seq(pkt);
    check("t6_hold_on", 32'(cpu_hold), 32'd1);
    load_en = 1'b0;
    idle(1);
    check_status("t6_off", 1'b0, 1'b0, 1'b0);
    pkt = '{8'h33, 8'h44, 8'h00};
    send_seq(pkt);
    check_status("t6_off_rest", 1'b0, 1'b0, 1'b0);
    check("t6_sb_left", 32'(sb.size()), 32'd0);
    load_en = 1'b1;
    idle(20);

    // 6b: asynchronous reset mid-packet
    expect_wr(6'd2 - 6'd2, 32'h4433_2211);
    pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_seq(pkt);
    check("t6_wdata_pre", wdata, 32'h4433_2211);
    check("t6_hold_pre", 32'(cpu_hold), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_we", 32'(we), 32'd0);
    check("t6_rst_waddr", 32'(waddr), 32'd0);
    check("t6_rst_wdata", wdata, 32'd0);
    check_status("t6_rst", 1'b0, 1'b0, 1'b0);
    check("t6_sb_left2", 32'(sb.size()), 32'd0);
    idle(5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
